// File: rtl/regbank_write_arbiter_pkg.sv
// Shared types and defaults for the register bank write arbiter.
package regbank_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 3;

  // bank_data value after reset
  localparam int BANK_DATA_RST = 0;

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Request side and bank write port of the arbiter.
// Optional macro REGBANK_ARB_R0_PROTECT_EN adds the wr_err pulse.
interface regbank_write_arbiter_if #(
  parameter int NUM_REQ = regbank_arb_pkg::NUM_REQ_DEF,
  parameter int DATA_W  = regbank_arb_pkg::DATA_W_DEF,
  parameter int ADDR_W  = regbank_arb_pkg::ADDR_W_DEF,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      bank_we;
  logic [ADDR_W-1:0]         bank_addr;
  logic [DATA_W-1:0]         bank_data;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;
`ifdef REGBANK_ARB_R0_PROTECT_EN
  logic                      wr_err;
`endif

  // requesters plus bank side, as seen by the testbench / surrounding logic
  modport master (
`ifdef REGBANK_ARB_R0_PROTECT_EN
    input  wr_err,
`endif
    output req, req_addr, req_data,
    input  ack, bank_we, bank_addr, bank_data, busy, grant_id
  );

  // the arbiter itself
  modport slave (
`ifdef REGBANK_ARB_R0_PROTECT_EN
    output wr_err,
`endif
    input  req, req_addr, req_data,
    output ack, bank_we, bank_addr, bank_data, busy, grant_id
  );

endinterface

// File: rtl/regbank_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Walk from farthest to nearest so the nearest candidate after 'last' wins.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    for (int off = N; off >= 1; off--) begin
      if (req[(int'(last) + off) % N]) begin
        valid = 1'b1;
        idx   = IW'((int'(last) + off) % N);
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter for the single write port of the register bank.
// Two-state FSM (IDLE/WRITE), all outputs registered, one write per 2 clocks.
// Optional macro REGBANK_ARB_R0_PROTECT_EN: register 0 becomes read-only
// through this port; such grants still ack but pulse wr_err instead of bank_we.
module regbank_write_arbiter #(
  parameter int NUM_REQ = regbank_arb_pkg::NUM_REQ_DEF,
  parameter int DATA_W  = regbank_arb_pkg::DATA_W_DEF,
  parameter int ADDR_W  = regbank_arb_pkg::ADDR_W_DEF,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  regbank_write_arbiter_if.slave  bus
);
  import regbank_arb_pkg::*;

  arb_state_e                      state;
  logic [NUM_REQ-1:0]              ack_q;
  logic                            bank_we_q;
  logic [ADDR_W-1:0]               bank_addr_q;
  logic [DATA_W-1:0]               bank_data_q;
  logic                            busy_q;
  logic [IDX_W-1:0]                grant_q;
`ifdef REGBANK_ARB_R0_PROTECT_EN
  logic                            wr_err_q;
`endif

  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_arr;
  logic [NUM_REQ-1:0][DATA_W-1:0]  data_arr;
  logic                            pick_vld;
  logic [IDX_W-1:0]                pick_idx;
  logic [NUM_REQ-1:0]              ack_nxt;
  logic                            wr_blk;

  assign addr_arr = bus.req_addr;
  assign data_arr = bus.req_data;

  rr_picker #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .req   (bus.req),
    .last  (grant_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // One-hot ack for the current pick.
  always_comb begin
    ack_nxt           = '0;
    ack_nxt[pick_idx] = 1'b1;
  end

`ifdef REGBANK_ARB_R0_PROTECT_EN
  assign wr_blk = (addr_arr[pick_idx] == '0);
`else
  assign wr_blk = 1'b0;
`endif

  // Grant FSM: IDLE picks and launches a one-cycle write, WRITE always returns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ack_q       <= '0;
      bank_we_q   <= 1'b0;
      bank_addr_q <= '0;
      bank_data_q <= DATA_W'(BANK_DATA_RST);
      busy_q      <= 1'b0;
      grant_q     <= IDX_W'(NUM_REQ - 1);
`ifdef REGBANK_ARB_R0_PROTECT_EN
      wr_err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= WRITE;
            busy_q    <= 1'b1;
            ack_q     <= ack_nxt;
            grant_q   <= pick_idx;
            bank_we_q <= !wr_blk;
            // blocked grants leave the bank port values untouched
            if (!wr_blk) begin
              bank_addr_q <= addr_arr[pick_idx];
              bank_data_q <= data_arr[pick_idx];
            end
`ifdef REGBANK_ARB_R0_PROTECT_EN
            wr_err_q  <= wr_blk;
`endif
          end else begin
            ack_q     <= '0;
            bank_we_q <= 1'b0;
`ifdef REGBANK_ARB_R0_PROTECT_EN
            wr_err_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          ack_q     <= '0;
          bank_we_q <= 1'b0;
`ifdef REGBANK_ARB_R0_PROTECT_EN
          wr_err_q  <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.bank_we   = bank_we_q;
  assign bus.bank_addr = bank_addr_q;
  assign bus.bank_data = bank_data_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;
`ifdef REGBANK_ARB_R0_PROTECT_EN
  assign bus.wr_err    = wr_err_q;
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Self-checking bench for regbank_write_arbiter: scoreboard of expected grants,
// table of single-requester writes, hand sequences for contention and reset.
module tb_regbank_write_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regbank_write_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus();

  regbank_write_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic        we;
  } exp_t;

  typedef struct {
    int          id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  exp_t sb[$];
  int   ack_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  vec_t tbl[5];
  logic [DW-1:0] bank [8];
  logic [DW-1:0] prev;

  // register bank model behind the write port
  always @(posedge clock) if (bus.bank_we) bank[bus.bank_addr] <= bus.bank_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic we_of(input logic [AW-1:0] a);
`ifdef REGBANK_ARB_R0_PROTECT_EN
    return (a != '0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic raise(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[id*AW +: AW] = a;
    bus.req_data[id*DW +: DW] = d;
    bus.req[id] = 1'b1;
  endtask

  task automatic push(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.id = id; e.addr = a; e.data = d; e.we = we_of(a);
    sb.push_back(e);
  endtask

  // one clock: sample on negedge, compare grants against the scoreboard,
  // and drop req for the acked requester
  task automatic cyc();
    exp_t e;
    @(negedge clock);
    cyc_n++;
    if (bus.ack != '0) begin
      ack_cyc.push_back(cyc_n);
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(bus.ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_onehot", 32'(bus.ack), 32'(1 << e.id));
        chk("grant_id", 32'(bus.grant_id), 32'(e.id));
        chk("bank_we", 32'(bus.bank_we), 32'(e.we));
        chk("busy", 32'(bus.busy), 32'd1);
        if (e.we) begin
          chk("bank_addr", 32'(bus.bank_addr), 32'(e.addr));
          chk("bank_data", 32'(bus.bank_data), 32'(e.data));
        end
`ifdef REGBANK_ARB_R0_PROTECT_EN
        chk("wr_err", 32'(bus.wr_err), 32'(!e.we));
`endif
      end
      for (int i = 0; i < NR; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
    end else begin
      chk("we_without_ack", 32'(bus.bank_we), 32'd0);
    end
  endtask

  task automatic run(input int maxc);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy) && n < maxc) begin
      cyc();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    tbl[0] = '{1, 3'd5, 16'hA5A5};
    tbl[1] = '{3, 3'd7, 16'hFFFF};
    tbl[2] = '{2, 3'd1, 16'h1234};
    tbl[3] = '{0, 3'd6, 16'h0F0F};
    tbl[4] = '{3, 3'd3, 16'hC3C3};

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_bank_we", 32'(bus.bank_we), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd3);
    chk("rst_bank_addr", 32'(bus.bank_addr), 32'd0);
    chk("rst_bank_data", 32'(bus.bank_data), 32'd0);
    reset = 1'b0;
    cyc();

    // requester 0 alone: ack one edge after req is sampled
    raise(0, 3'd2, 16'h6666);
    push(0, 3'd2, 16'h6666);
    cyc();
    chk("first_latency", 32'(sb.size()), 32'd0);
    run(10);
    chk("bank2", 32'(bank[2]), 32'h6666);

    // single-requester table
    for (int k = 0; k < 5; k++) begin
      raise(tbl[k].id, tbl[k].addr, tbl[k].data);
      push(tbl[k].id, tbl[k].addr, tbl[k].data);
      run(10);
      chk("tbl_bank", 32'(bank[tbl[k].addr]), 32'(tbl[k].data));
      chk("tbl_grant", 32'(bus.grant_id), 32'(tbl[k].id));
    end

    // all four at once from grant_id=3: order 0,1,2,3, two clocks apart
    ack_cyc.delete();
    for (int i = 0; i < NR; i++) begin
      raise(i, AW'(i), DW'(16'h0010 + i));
      push(i, AW'(i), DW'(16'h0010 + i));
    end
    run(30);
    chk("all4_count", 32'(ack_cyc.size()), 32'd4);
    if (ack_cyc.size() == 4)
      for (int i = 1; i < 4; i++) chk("all4_gap", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd2);
    chk("all4_grant", 32'(bus.grant_id), 32'd3);
    for (int i = 1; i < NR; i++) chk("all4_bank", 32'(bank[i]), 32'(16'h0010 + i));

    // wrap-around: 0 beats 3 after grant_id=3
    raise(3, 3'd4, 16'h3333);
    raise(0, 3'd5, 16'h0505);
    push(0, 3'd5, 16'h0505);
    push(3, 3'd4, 16'h3333);
    run(10);
    chk("wrap_grant", 32'(bus.grant_id), 32'd3);
    chk("wrap_bank4", 32'(bank[4]), 32'h3333);

    // idle: outputs hold
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_ack", 32'(bus.ack), 32'd0);
      chk("idle_addr", 32'(bus.bank_addr), 32'd4);
      chk("idle_data", 32'(bus.bank_data), 32'h3333);
    end

    // reset in the middle of WRITE
    raise(1, 3'd6, 16'hDEAD);
    push(1, 3'd6, 16'hDEAD);
    cyc();
    chk("mid_ack_seen", 32'(sb.size()), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(bus.bank_we), 32'd0);
    chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_grant", 32'(bus.grant_id), 32'd3);
    @(negedge clock);
    reset = 1'b0;
    cyc();
    chk("mid_rst_bank6", 32'(bank[6]), 32'h0F0F);

    // write to register 0 from requester 1
    prev = bank[0];
    raise(1, 3'd0, 16'h0002);
    push(1, 3'd0, 16'h0002);
    run(10);
    chk("r0_grant", 32'(bus.grant_id), 32'd1);
`ifdef REGBANK_ARB_R0_PROTECT_EN
    chk("r0_protected", 32'(bank[0]), 32'(prev));
`else
    chk("r0_written", 32'(bank[0]), 32'h0002);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
